seq_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier with a start/busy/done handshake; next-generation replacement for the fixed 4x4 multiplier. Operands are captured on a start pulse. One multiplier bit is retired per clock. The 2*WIDTH-bit product is published with a one-cycle done strobe. An optional signed mode is compiled in by macro. The block sits between operand-producing control logic and any consumer that samples the product on done.

---
 rtl/seq_multiplier.sv | 164 ++++++++++++++++
 tb/tb_seq_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add multiplier with a start/busy/done
// handshake. Operands are captured on start. One multiplier bit is retired per
// clock, so CALC lasts exactly WIDTH cycles. The 2*WIDTH-bit product is then
// published together with a one-cycle done strobe.
//
// Optional feature macro: MULT_SIGNED_EN
//   defined   -> sgn is honoured: operands are loaded as magnitudes and the
//                result is negated when the operand signs differ.
//   undefined -> sgn is ignored and every operation is unsigned. The cycle
//                timing is the same in both builds.
//
// Reset is asynchronous and active-low on rst. It discards any operation in
// flight.

module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Counter just wide enough to reach WIDTH-1 (WIDTH is 2..32).
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH:0]      acc_hi;     // upper partial product plus carry bit
    logic [WIDTH-1:0]    mr;         // multiplier; low product bits shift in here
    logic [WIDTH-1:0]    md;         // multiplicand (as a magnitude in signed mode)
    logic [CW-1:0]       count;

    // Values captured when a start is accepted.
    logic [WIDTH-1:0]    load_mr;
    logic [WIDTH-1:0]    load_md;

    // One-step datapath. The add and the shift are folded into a single cycle.
    logic [WIDTH:0]      md_add;
    logic [WIDTH:0]      add_sum;
    logic [WIDTH:0]      acc_shift;
    logic [WIDTH-1:0]    mr_shift;
    logic [2*WIDTH-1:0]  final_raw;
    logic [2*WIDTH-1:0]  final_result;

`ifdef MULT_SIGNED_EN
    logic                neg;
    logic                load_neg;

    // Convert two's-complement operands to magnitudes. -2^(WIDTH-1) negates
    // to itself, and that bit pattern read as unsigned is the correct magnitude.
    always_comb begin
        load_mr  = multiplier;
        load_md  = multiplicand;
        load_neg = 1'b0;
        if (sgn) begin
            if (multiplier[WIDTH-1]) begin
                load_mr = -multiplier;
            end
            if (multiplicand[WIDTH-1]) begin
                load_md = -multiplicand;
            end
            load_neg = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
        end
    end
`else
    // sgn has no meaning in the unsigned-only build.
    logic                sgn_unused;
    assign sgn_unused = sgn;

    // Operands are always loaded as they are.
    always_comb begin
        load_mr = multiplier;
        load_md = multiplicand;
    end
`endif

    // Conditional add of the multiplicand, then shift {carry, acc_hi, mr} right by one.
    always_comb begin
        md_add    = mr[0] ? {1'b0, md} : '0;
        add_sum   = acc_hi + md_add;
        acc_shift = {1'b0, add_sum[WIDTH:1]};
        mr_shift  = {add_sum[0], mr[WIDTH-1:1]};
        final_raw = {acc_shift[WIDTH-1:0], mr_shift};
    end

    // Sign correction of the completed magnitude product.
    always_comb begin
`ifdef MULT_SIGNED_EN
        final_result = neg ? -final_raw : final_raw;
`else
        final_result = final_raw;
`endif
    end

    // Control FSM and datapath registers. All outputs are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            acc_hi  <= '0;
            mr      <= '0;
            md      <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
`ifdef MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mr     <= load_mr;
                        md     <= load_md;
                        acc_hi <= '0;
                        count  <= '0;
`ifdef MULT_SIGNED_EN
                        neg    <= load_neg;
`endif
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc_hi <= acc_shift;
                    mr     <= mr_shift;
                    count  <= count + 1'b1;
                    // The last step publishes the product in the same edge.
                    // done is then high during the DONE cycle.
                    if (count == LAST_COUNT) begin
                        product <= final_result;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // start is ignored here. A held start is taken on the next edge.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier. One 4-bit and one 8-bit instance are
// checked for reset state, products, latency, the held-start cadence, and
// mid-operation reset. The signed cases follow MULT_SIGNED_EN.

module tb_seq_multiplier;

    logic        clk;
    logic        rst;

    logic        start4, sgn4, busy4, done4;
    logic [3:0]  mr4, md4;
    logic [7:0]  prod4;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  mr8, md8;
    logic [15:0] prod8;

    int checks;
    int errors;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .sgn          (sgn4),
        .multiplier   (mr4),
        .multiplicand (md4),
        .busy         (busy4),
        .done         (done4),
        .product      (prod4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
        .sgn          (sgn8),
        .multiplier   (mr8),
        .multiplicand (md8),
        .busy         (busy8),
        .done         (done8),
        .product      (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Run one operation on the selected instance (w = 4 or 8).
    // Checks busy after E0, done exactly WIDTH edges later, the product,
    // and the return to idle one edge after that.
    task automatic run_op(input string tag, input int w, input logic [7:0] a,
                          input logic [7:0] b, input logic s, input logic [15:0] exp);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        if (w == 4) begin mr4 = a[3:0]; md4 = b[3:0]; sgn4 = s; start4 = 1'b1; end
        else        begin mr8 = a;      md8 = b;      sgn8 = s; start8 = 1'b1; end
        @(posedge clk); #1;                       // E0
        check_val({tag, "_busy_start"}, (w == 4) ? busy4 : busy8, 1);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        // Operands changed while busy must not matter.
        if (w == 4) begin mr4 = 4'h0; md4 = 4'h0; end
        else        begin mr8 = 8'h0; md8 = 8'h0; end
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (((w == 4) ? done4 : done8) === 1'b1) begin
                seen = 1;
                lat  = i;
            end
        end
        check_val({tag, "_latency"}, lat, w);
        check_val({tag, "_product"}, (w == 4) ? {24'h0, prod4} : {16'h0, prod8}, {16'h0, exp});
        @(posedge clk); #1;                       // E_WIDTH+1
        check_val({tag, "_idle"}, (w == 4) ? {busy4, done4} : {busy8, done8}, 0);
    endtask

    initial begin
        bit saw_done;
        int done_edges[$];
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start4 = 0; sgn4 = 0; mr4 = 0; md4 = 0;
        start8 = 0; sgn8 = 0; mr8 = 0; md8 = 0;
        #12;
        check_val("reset_busy_done4", {busy4, done4}, 0);
        check_val("reset_product4", prod4, 0);
        check_val("reset_product8", prod8, 0);
        @(negedge clk);
        rst = 1'b1;

        // Unsigned: 13*11=143. Max 8-bit operands. Zero operand takes the full latency.
        run_op("u4_13x11", 4, 8'd13, 8'd11, 1'b0, 16'h008F);
        run_op("u8_255x255", 8, 8'd255, 8'd255, 1'b0, 16'hFE01);
        run_op("u8_0x200", 8, 8'd0, 8'd200, 1'b0, 16'h0000);
        run_op("u4_15x1", 4, 8'd15, 8'd1, 1'b0, 16'h000F);

`ifdef MULT_SIGNED_EN
        run_op("s4_m8x7", 4, 8'h08, 8'h07, 1'b1, 16'h00C8);
        run_op("s4_m8xm8", 4, 8'h08, 8'h08, 1'b1, 16'h0040);
        run_op("s4_m3x5", 4, 8'h0D, 8'h05, 1'b1, 16'h00F1);
        run_op("s8_m1x127", 8, 8'hFF, 8'h7F, 1'b1, 16'hFF81);
        run_op("s4_sgn0_15x15", 4, 8'h0F, 8'h0F, 1'b0, 16'h00E1);
`else
        run_op("nosgn4_15x15", 4, 8'h0F, 8'h0F, 1'b1, 16'h00E1);
        run_op("nosgn8_m8x7", 8, 8'hF8, 8'h07, 1'b1, 16'h06C8);
`endif

        // Start held high. Accepts at E0 and again at E6; done at E4 and E10.
        @(negedge clk);
        mr4 = 4'd13; md4 = 4'd11; sgn4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;                       // E0
        @(negedge clk);
        mr4 = 4'd2; md4 = 4'd3;                   // change while busy
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                done_edges.push_back(i);
                check_val($sformatf("held_product_e%0d", i), prod4, (i == 4) ? 8'd143 : 8'd6);
            end
            if (i == 5) check_val("held_idle_gap", busy4, 0);
            if (i == 6) begin
                check_val("held_reaccept", busy4, 1);
                @(negedge clk);
                start4 = 1'b0;
            end
        end
        check_val("held_done_count", done_edges.size(), 2);
        if (done_edges.size() == 2) begin
            check_val("held_done_edge0", done_edges[0], 4);
            check_val("held_done_edge1", done_edges[1], 10);
        end

        // Reset during the third CALC cycle. No done may follow.
        @(negedge clk);
        mr4 = 4'd9; md4 = 4'd7; start4 = 1'b1;
        @(posedge clk);                           // E0
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);                           // E1
        @(posedge clk);                           // E2
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_mid_busy_done", {busy4, done4}, 0);
        check_val("rst_mid_product", prod4, 0);
        #3;
        rst = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) saw_done = 1;
        end
        check_val("rst_no_done", saw_done, 0);
        run_op("post_rst_9x7", 4, 8'd9, 8'd7, 1'b0, 16'd63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
